// File: rtl/cpu_controller.sv
// -----------------------------------------------------------------------------
// cpu_controller
//
// Phase sequencer for the 5-bit accumulator CPU. An 8-phase instruction cycle
// (fetch in phases 0-3, execute in phases 4-7) drives every datapath strobe:
// address mux select, memory read/write, IR/AC/PC loads, PC increment and the
// data-bus enable. Strobes are a pure decode of the current phase, the opcode
// from the IR, the ALU zero flag and the sticky halted flag.
//
// Optional feature macro: CTRL_WAIT_STATE_EN
//   defined   : memory phases stall until mem_ready, with a stall watchdog
//               (WAIT_TIMEOUT cycles) that raises mem_err and halts.
//   undefined : mem_ready is ignored, no stalls, mem_err is constant 0.
//
// Parameters
//   WAIT_TIMEOUT  stall cycles tolerated before a fault (1..255), wait-state
//                 build only.
//
// Ports
//   clk        in   rising-edge clock
//   rst_n      in   asynchronous active-low reset
//   opcode     in   [2:0] IR opcode (HLT,SKZ,ADD,AND,XOR,LDA,STO,JMP = 0..7)
//   zero       in   accumulator-zero flag
//   mem_ready  in   memory completion (wait-state build only)
//   sel        out  address mux select: 1 = pc_addr, 0 = ir_addr
//   rd, wr     out  memory read / write strobes
//   ld_ir      out  load instruction register
//   ld_ac      out  load accumulator
//   ld_pc      out  load program counter
//   inc_pc     out  increment program counter
//   data_e     out  drive AC onto the data bus
//   halt       out  halted indication (also asserted in phase 4 of HLT)
//   mem_err    out  sticky wait-state timeout fault
//   phase      out  [2:0] current phase, for debug
// -----------------------------------------------------------------------------
module cpu_controller #(
    parameter int WAIT_TIMEOUT = 15
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [2:0] opcode,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       sel,
    output logic       rd,
    output logic       wr,
    output logic       ld_ir,
    output logic       ld_ac,
    output logic       ld_pc,
    output logic       inc_pc,
    output logic       data_e,
    output logic       halt,
    output logic       mem_err,
    output logic [2:0] phase
);

    // Instruction-cycle phases, in execution order; the encoding equals the
    // phase number so a plain +1 walks the cycle and wraps 7 -> 0.
    typedef enum logic [2:0] {
        INST_ADDR  = 3'd0,
        INST_FETCH = 3'd1,
        INST_LOAD  = 3'd2,
        IDLE       = 3'd3,
        OP_ADDR    = 3'd4,
        OP_FETCH   = 3'd5,
        ALU_OP     = 3'd6,
        STORE      = 3'd7
    } phase_t;

    localparam logic [2:0] OP_HLT = 3'd0;
    localparam logic [2:0] OP_SKZ = 3'd1;
    localparam logic [2:0] OP_ADD = 3'd2;
    localparam logic [2:0] OP_AND = 3'd3;
    localparam logic [2:0] OP_XOR = 3'd4;
    localparam logic [2:0] OP_LDA = 3'd5;
    localparam logic [2:0] OP_STO = 3'd6;
    localparam logic [2:0] OP_JMP = 3'd7;

    phase_t phase_reg;
    phase_t phase_next;
    logic   halted_reg;
    logic   halted_next;

    // Stall / watchdog hooks; tied off in the default build.
    logic   stall;
    logic   timeout;

    // -------------------------------------------------------------------------
    // Opcode classification
    // -------------------------------------------------------------------------
    logic is_hlt;
    logic is_skz;
    logic is_sto;
    logic is_jmp;
    logic is_aluop;

    assign is_hlt   = (opcode == OP_HLT);
    assign is_skz   = (opcode == OP_SKZ);
    assign is_sto   = (opcode == OP_STO);
    assign is_jmp   = (opcode == OP_JMP);
    // Every instruction that reads its operand from memory into the AC.
    assign is_aluop = (opcode == OP_ADD) || (opcode == OP_AND) ||
                      (opcode == OP_XOR) || (opcode == OP_LDA);

    // -------------------------------------------------------------------------
    // Strobe decode. Purely combinational so strobes are valid in the same
    // cycle as the phase and are frozen automatically while a phase is held.
    // -------------------------------------------------------------------------
    always_comb begin
        sel    = 1'b0;
        rd     = 1'b0;
        wr     = 1'b0;
        ld_ir  = 1'b0;
        ld_ac  = 1'b0;
        ld_pc  = 1'b0;
        inc_pc = 1'b0;
        data_e = 1'b0;
        halt   = 1'b0;

        if (halted_reg) begin
            // Parked: only the halt indication, address mux on ir_addr.
            halt = 1'b1;
        end else begin
            case (phase_reg)
                INST_ADDR: begin
                    sel = 1'b1;
                end
                INST_FETCH: begin
                    sel = 1'b1;
                    rd  = 1'b1;
                end
                INST_LOAD, IDLE: begin
                    sel   = 1'b1;
                    rd    = 1'b1;
                    ld_ir = 1'b1;
                end
                OP_ADDR: begin
                    inc_pc = 1'b1;
                    halt   = is_hlt;
                end
                OP_FETCH: begin
                    rd = is_aluop;
                end
                ALU_OP: begin
                    rd     = is_aluop;
                    inc_pc = is_skz && zero;   // skip the next instruction
                    ld_pc  = is_jmp;
                    data_e = is_sto;
                end
                STORE: begin
                    rd     = is_aluop;
                    ld_ac  = is_aluop;
                    inc_pc = is_jmp;
                    ld_pc  = is_jmp;
                    wr     = is_sto;
                    data_e = is_sto;
                end
                default: begin
                    sel = 1'b0;
                end
            endcase
        end
    end

`ifdef CTRL_WAIT_STATE_EN
    // -------------------------------------------------------------------------
    // Wait states: the instruction fetch, and operand read/write phases, hold
    // until memory reports completion. A counter of held cycles acts as a
    // watchdog; hitting WAIT_TIMEOUT latches mem_err and parks the sequencer.
    // -------------------------------------------------------------------------
    localparam logic [7:0] WAIT_LAST = 8'(WAIT_TIMEOUT - 1);

    logic [7:0] wait_cnt_reg;
    logic [7:0] wait_cnt_next;
    logic       mem_err_reg;
    logic       mem_err_next;
    logic       hold_req;

    always_comb begin
        hold_req = 1'b0;
        case (phase_reg)
            INST_FETCH: hold_req = 1'b1;
            ALU_OP:     hold_req = rd;
            STORE:      hold_req = rd || wr;
            default:    hold_req = 1'b0;
        endcase
    end

    assign stall   = !halted_reg && hold_req && !mem_ready;
    // The edge that would make the counter reach WAIT_TIMEOUT is the fault edge.
    assign timeout = stall && (wait_cnt_reg == WAIT_LAST);

    always_comb begin
        wait_cnt_next = stall ? wait_cnt_reg + 8'd1 : 8'd0;
        mem_err_next  = mem_err_reg || timeout;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt_reg <= 8'd0;
            mem_err_reg  <= 1'b0;
        end else begin
            wait_cnt_reg <= wait_cnt_next;
            mem_err_reg  <= mem_err_next;
        end
    end

    assign mem_err = mem_err_reg;
`else
    // Without wait states memory is assumed single-cycle.
    logic [1:0] unused_inputs;

    assign unused_inputs = {mem_ready, WAIT_TIMEOUT[0]};
    assign stall         = 1'b0;
    assign timeout       = 1'b0;
    assign mem_err       = 1'b0;
`endif

    // -------------------------------------------------------------------------
    // Phase sequencing. HLT in phase 4 takes priority over everything (phase
    // 4 never stalls anyway); a watchdog timeout halts in place.
    // -------------------------------------------------------------------------
    always_comb begin
        phase_next  = phase_reg;
        halted_next = halted_reg;

        if (!halted_reg) begin
            if ((phase_reg == OP_ADDR) && is_hlt) begin
                halted_next = 1'b1;
            end else if (timeout) begin
                halted_next = 1'b1;
            end else if (!stall) begin
                phase_next = phase_t'(phase_reg + 3'd1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase_reg  <= INST_ADDR;
            halted_reg <= 1'b0;
        end else begin
            phase_reg  <= phase_next;
            halted_reg <= halted_next;
        end
    end

    assign phase = phase_reg;

endmodule

// File: tb/tb_cpu_controller.sv
// -----------------------------------------------------------------------------
// tb_cpu_controller
//
// Self-checking bench for cpu_controller: reset behaviour, a table of
// per-phase strobe vectors, randomized opcode/zero stimulus against a
// behavioural instruction-level model, and hand-written sequences for halt,
// reset abort and (when CTRL_WAIT_STATE_EN is defined) wait states/timeout.
// -----------------------------------------------------------------------------
module tb_cpu_controller;

    localparam int WT = 15;

    // Strobe word layout: {sel, rd, wr, ld_ir, ld_ac, ld_pc, inc_pc, data_e, halt, mem_err}
    localparam logic [9:0] W_SEL  = 10'h200;
    localparam logic [9:0] W_RD   = 10'h100;
    localparam logic [9:0] W_WR   = 10'h080;
    localparam logic [9:0] W_LDIR = 10'h040;
    localparam logic [9:0] W_LDAC = 10'h020;
    localparam logic [9:0] W_LDPC = 10'h010;
    localparam logic [9:0] W_INC  = 10'h008;
    localparam logic [9:0] W_DE   = 10'h004;
    localparam logic [9:0] W_HALT = 10'h002;
    localparam logic [9:0] W_ERR  = 10'h001;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [2:0] opcode;
    logic       zero;
    logic       mem_ready;
    logic       sel, rd, wr, ld_ir, ld_ac, ld_pc, inc_pc, data_e, halt, mem_err;
    logic [2:0] phase;
    logic [9:0] word;

    always #5 clk = ~clk;

    cpu_controller #(.WAIT_TIMEOUT(WT)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .opcode    (opcode),
        .zero      (zero),
        .mem_ready (mem_ready),
        .sel       (sel),
        .rd        (rd),
        .wr        (wr),
        .ld_ir     (ld_ir),
        .ld_ac     (ld_ac),
        .ld_pc     (ld_pc),
        .inc_pc    (inc_pc),
        .data_e    (data_e),
        .halt      (halt),
        .mem_err   (mem_err),
        .phase     (phase)
    );

    assign word = {sel, rd, wr, ld_ir, ld_ac, ld_pc, inc_pc, data_e, halt, mem_err};

    int n_checks = 0;
    int n_errors = 0;

    // ------------------------------------------------------------------
    // Reference model: what each instruction does in each phase, written
    // instruction by instruction (fetch is common, execute per opcode).
    // ------------------------------------------------------------------
    function automatic logic [9:0] ref_word(int ph, logic [2:0] op, logic z, bit hl, bit er);
        logic [9:0] w;
        if (hl) return W_HALT | (er ? W_ERR : 10'h000);
        if (ph == 0) return W_SEL;
        if (ph == 1) return W_SEL | W_RD;
        if (ph == 2 || ph == 3) return W_SEL | W_RD | W_LDIR;
        if (ph == 4) return W_INC | ((op == 3'd0) ? W_HALT : 10'h000);
        w = 10'h000;
        case (op)
            3'd2, 3'd3, 3'd4, 3'd5: begin   // ADD/AND/XOR/LDA: read operand, load AC at end
                w = W_RD;
                if (ph == 7) w = W_RD | W_LDAC;
            end
            3'd1: if (ph == 6 && z) w = W_INC;  // SKZ skips when zero
            3'd6: w = (ph == 7) ? (W_WR | W_DE) : ((ph == 6) ? W_DE : 10'h000);
            3'd7: w = (ph == 7) ? (W_LDPC | W_INC) : ((ph == 6) ? W_LDPC : 10'h000);
            default: w = 10'h000;
        endcase
        return w;
    endfunction

    function automatic bit ref_hold(int ph, logic [2:0] op, logic z);
`ifdef CTRL_WAIT_STATE_EN
        logic [9:0] w;
        w = ref_word(ph, op, z, 1'b0, 1'b0);
        return (ph == 1) || (ph == 6 && (w & W_RD) != 0) ||
               (ph == 7 && (w & (W_RD | W_WR)) != 0);
`else
        return (ph < 0) && (op == 3'd0) && z;
`endif
    endfunction

    int m_phase  = 0;
    bit m_halted = 1'b0;
    bit m_err    = 1'b0;
    int m_wait   = 0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_phase  <= 0;
            m_halted <= 1'b0;
            m_err    <= 1'b0;
            m_wait   <= 0;
        end else if (!m_halted) begin
            if (m_phase == 4 && opcode == 3'd0) begin
                m_halted <= 1'b1;
            end else if (ref_hold(m_phase, opcode, zero) && !mem_ready) begin
                if (m_wait + 1 >= WT) begin
                    m_halted <= 1'b1;
                    m_err    <= 1'b1;
                end
                m_wait <= m_wait + 1;
            end else begin
                m_phase <= (m_phase + 1) % 8;
                m_wait  <= 0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Helpers
    // ------------------------------------------------------------------
    task automatic cmp(string name, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_model(string name);
        #1;
        cmp({name, "_phase"}, 32'(phase), 32'(m_phase));
        cmp({name, "_strobes"}, 32'(word),
            32'(ref_word(m_phase, opcode, zero, m_halted, m_err)));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic goto_phase(int ph, string name);
        int n;
        n = 0;
        while (m_phase != ph && n < 40) begin
            tick();
            n++;
        end
        if (m_phase != ph) cmp({name, "_reach_phase"}, 32'(m_phase), 32'(ph));
    endtask

    task automatic reset_pulse(string name);
        #2;
        rst_n = 1'b0;
        #1;
        cmp({name, "_rst_phase"}, 32'(phase), 32'd0);
        cmp({name, "_rst_strobes"}, 32'(word), 32'(W_SEL));
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        cmp({name, "_post_rst_phase"}, 32'(phase), 32'd1);
        $display("reset pulse %s: phase=%0d word=%h", name, phase, word);
    endtask

    typedef struct {
        logic [2:0] op;
        logic       z;
        logic [2:0] ph;
        logic [9:0] exp;
    } vec_t;

    function automatic vec_t mk(logic [2:0] op, logic z, logic [2:0] ph, logic [9:0] exp);
        vec_t v;
        v.op = op; v.z = z; v.ph = ph; v.exp = exp;
        return v;
    endfunction

    vec_t tbl[20];

    initial begin
        // Per-phase expectations taken directly from the instruction table.
        tbl[0]  = mk(3'd5, 1'b0, 3'd1, W_SEL | W_RD);
        tbl[1]  = mk(3'd5, 1'b0, 3'd2, W_SEL | W_RD | W_LDIR);
        tbl[2]  = mk(3'd5, 1'b0, 3'd3, W_SEL | W_RD | W_LDIR);
        tbl[3]  = mk(3'd5, 1'b0, 3'd4, W_INC);
        tbl[4]  = mk(3'd5, 1'b0, 3'd5, W_RD);
        tbl[5]  = mk(3'd5, 1'b0, 3'd6, W_RD);
        tbl[6]  = mk(3'd5, 1'b0, 3'd7, W_RD | W_LDAC);
        tbl[7]  = mk(3'd5, 1'b0, 3'd0, W_SEL);
        tbl[8]  = mk(3'd1, 1'b1, 3'd4, W_INC);
        tbl[9]  = mk(3'd1, 1'b1, 3'd5, 10'h000);
        tbl[10] = mk(3'd1, 1'b1, 3'd6, W_INC);
        tbl[11] = mk(3'd1, 1'b1, 3'd7, 10'h000);
        tbl[12] = mk(3'd1, 1'b0, 3'd6, 10'h000);
        tbl[13] = mk(3'd1, 1'b0, 3'd7, 10'h000);
        tbl[14] = mk(3'd6, 1'b0, 3'd6, W_DE);
        tbl[15] = mk(3'd6, 1'b0, 3'd7, W_WR | W_DE);
        tbl[16] = mk(3'd7, 1'b0, 3'd6, W_LDPC);
        tbl[17] = mk(3'd7, 1'b0, 3'd7, W_LDPC | W_INC);
        tbl[18] = mk(3'd2, 1'b0, 3'd5, W_RD);
        tbl[19] = mk(3'd4, 1'b1, 3'd7, W_RD | W_LDAC);

        opcode    = 3'd5;
        zero      = 1'b0;
        mem_ready = 1'b1;
        rst_n     = 1'b1;
        #1 rst_n  = 1'b0;
        #1;
        cmp("init_rst_phase", 32'(phase), 32'd0);
        cmp("init_rst_strobes", 32'(word), 32'(W_SEL));
        #10 rst_n = 1'b1;

        // First edges after release walk 1,2,3.
        for (int i = 1; i <= 3; i++) begin
            tick();
            cmp($sformatf("release_phase%0d", i), 32'(phase), 32'(i));
        end

        // Reset asserted mid-instruction (phase 5) aborts immediately.
        goto_phase(5, "abort");
        reset_pulse("abort_in_phase5");
        tick();
        cmp("abort_then_phase2", 32'(phase), 32'd2);

        // Table-driven per-phase vectors.
        for (int i = 0; i < 20; i++) begin
            opcode = tbl[i].op;
            zero   = tbl[i].z;
            goto_phase(int'(tbl[i].ph), $sformatf("vec%0d", i));
            #1;
            cmp($sformatf("vec%0d_strobes", i), 32'(word), 32'(tbl[i].exp));
            cmp($sformatf("vec%0d_phase", i), 32'(phase), 32'(tbl[i].ph));
            $display("vec %0d: op=%0d z=%0d phase=%0d word=%h", i, tbl[i].op, tbl[i].z, phase, word);
        end

        // One instruction is exactly 8 cycles.
        opcode = 3'd5;
        goto_phase(0, "len");
        repeat (8) tick();
        cmp("instr_len_8", 32'(phase), 32'd0);
        $display("instruction length: phase after 8 cycles=%0d", phase);

        // Randomized opcode/zero (HLT excluded) against the model.
        for (int i = 0; i < 400; i++) begin
            tick();
            opcode = 3'($urandom_range(1, 7));
            zero   = 1'($urandom);
`ifdef CTRL_WAIT_STATE_EN
            mem_ready = ($urandom_range(0, 3) != 0);
`else
            mem_ready = 1'($urandom);
`endif
            check_model($sformatf("rand%0d", i));
        end
        $display("random: %0d cycles checked against model", 400);
        mem_ready = 1'b1;

`ifdef CTRL_WAIT_STATE_EN
        // Fetch stall: mem_ready low for 3 cycles in phase 1.
        opcode = 3'd5;
        goto_phase(0, "fstall");
        tick();
        mem_ready = 1'b0;
        #1 cmp("fstall_c1_phase", 32'(phase), 32'd1);
        for (int i = 2; i <= 4; i++) begin
            tick();
            if (i == 4) mem_ready = 1'b1;
            #1;
            cmp($sformatf("fstall_c%0d_phase", i), 32'(phase), 32'd1);
            cmp($sformatf("fstall_c%0d_rd", i), 32'(rd), 32'd1);
        end
        tick();
        cmp("fstall_then_phase2", 32'(phase), 32'd2);
        $display("fetch stall: phase=%0d", phase);

        // Watchdog: STO held in phase 7 with mem_ready low.
        opcode = 3'd6;
        goto_phase(7, "tmo");
        mem_ready = 1'b0;
        for (int i = 1; i < WT; i++) begin
            tick();
            cmp($sformatf("tmo_held%0d_err", i), 32'(mem_err), 32'd0);
            cmp($sformatf("tmo_held%0d_wr", i), 32'(wr), 32'd1);
        end
        tick();
        cmp("tmo_mem_err", 32'(mem_err), 32'd1);
        cmp("tmo_halt", 32'(halt), 32'd1);
        cmp("tmo_sel", 32'(sel), 32'd0);
        cmp("tmo_strobes", 32'(word), 32'(W_HALT | W_ERR));
        cmp("tmo_phase", 32'(phase), 32'd7);
        repeat (3) tick();
        cmp("tmo_phase_frozen", 32'(phase), 32'd7);
        $display("timeout: mem_err=%0d halt=%0d phase=%0d", mem_err, halt, phase);
        mem_ready = 1'b1;
        reset_pulse("after_timeout");
        cmp("after_timeout_err_clear", 32'(mem_err), 32'd0);
`endif

        // HLT: halt in phase 4, then frozen with only halt asserted.
        opcode = 3'd0;
        goto_phase(4, "hlt");
        #1;
        cmp("hlt_phase4_strobes", 32'(word), 32'(W_INC | W_HALT));
        for (int i = 0; i < 22; i++) begin
            tick();
            zero = 1'($urandom);
            opcode = 3'($urandom);
            #1;
            cmp($sformatf("hlt_hold%0d_phase", i), 32'(phase), 32'd4);
            cmp($sformatf("hlt_hold%0d_strobes", i), 32'(word), 32'(W_HALT));
        end
        $display("halt: held phase=%0d word=%h for 22 cycles", phase, word);
        opcode = 3'd5;
        reset_pulse("after_halt");
        tick();
        check_model("after_halt_model");

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    // Global watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "simulation time limit");
    end

endmodule

// File: doc/cpu_controller.md
# cpu_controller

Phase sequencer for the 5-bit accumulator CPU. It steps through an 8-phase instruction cycle and drives every datapath strobe: the `address_mux` select, memory read/write, IR/PC/AC loads, PC increment and data-bus enable. Inputs are the 3-bit opcode from the IR and the ALU zero flag. It sits between the IR/ALU and the address mux, PC, IR, AC and memory.

## Interface
- `WAIT_TIMEOUT`, default 15: maximum stall cycles on `mem_ready` before a fault. Only used with `CTRL_WAIT_STATE_EN`. Range 1–255.
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `opcode` in 3: IR opcode. Encodings:
  - 0 HLT, 1 SKZ, 2 ADD, 3 AND, 4 XOR, 5 LDA, 6 STO, 7 JMP.
- `zero` in 1: accumulator-zero flag.
- `mem_ready` in 1: memory completion; ignored unless the macro is defined.
- `sel` out 1: address mux select. 1 routes `pc_addr`; 0 routes `ir_addr`.
- `rd`, `wr` out 1 each: memory read/write strobes.
- `ld_ir`, `ld_ac`, `ld_pc`, `inc_pc` out 1 each: register load/increment strobes.
- `data_e` out 1: drive AC onto the data bus.
- `halt` out 1: sticky halted indication.
- `mem_err` out 1: sticky wait-state timeout fault.
- `phase` out 3: current phase, for debug.

## Operation
- The 3-bit phase register advances by 1 each cycle and wraps from 7 to 0. It does not advance while halted or stalled.
- Strobes are decoded combinationally from `phase`, `opcode`, `zero` and `halted`. ALUOP means opcode is ADD, AND, XOR or LDA. Any strobe not listed for a phase is 0.
  - Phase 0 INST_ADDR: sel=1.
  - Phase 1 INST_FETCH: sel=1, rd=1.
  - Phase 2 INST_LOAD: sel=1, rd=1, ld_ir=1.
  - Phase 3 IDLE: sel=1, rd=1, ld_ir=1.
  - Phase 4 OP_ADDR: sel=0, inc_pc=1, halt=(opcode==HLT).
  - Phase 5 OP_FETCH: sel=0, rd=ALUOP.
  - Phase 6 ALU_OP: sel=0, rd=ALUOP, inc_pc=(SKZ & zero), ld_pc=JMP, data_e=STO.
  - Phase 7 STORE: sel=0, rd=ALUOP, ld_ac=ALUOP, inc_pc=JMP, ld_pc=JMP, wr=STO, data_e=STO.
- Halt:
  - At the end of phase 4 with opcode HLT, the `halted` flag sets and `phase` freezes at 4.
  - While halted: `halt`=1, `sel`=0, all other strobes 0.
  - Only reset clears `halted`.
- `opcode` and `zero` are sampled combinationally. The IR must hold `opcode` stable from phase 4 through phase 7.

## Timing
- Reset (asynchronous, immediate):
  - `phase`=0, `halted`=0, `mem_err`=0, wait counter=0.
  - Outputs: `sel`=1, `phase`=0, every other output 0.
  - Reset asserted mid-instruction aborts the instruction, with no partial strobes after assertion.
- First rising edge after `rst_n` deasserts moves to phase 1.
- Without stalls, one instruction takes exactly 8 cycles.
- Strobes are valid in the same cycle as `phase`. Datapath registers capture on the edge that ends that phase.
- Simultaneous HLT in phase 4 and any stall: HLT wins. The macro adds no stall in phase 4.

## Configuration
- `CTRL_WAIT_STATE_EN` defined:
  - Phases 1, 6 (only when `rd`=1) and 7 (when `rd` or `wr`=1) hold until the cycle `mem_ready`=1. Strobes stay constant during the hold.
  - The wait counter increments on each held cycle and clears when the phase advances.
  - If the counter reaches `WAIT_TIMEOUT` with `mem_ready`=0, then on that edge `mem_err` and `halted` set. Outputs then follow the halted values, including `sel`=0, and `phase` freezes at its current value.
- `CTRL_WAIT_STATE_EN` undefined:
  - `mem_ready` is ignored, there is no stall, and `mem_err` is constant 0.

## Test plan
- Reset: assert `rst_n`=0 while in phase 5 → same-cycle `phase`=0, `sel`=1, all other outputs 0. After release, `phase` goes 1,2,3….
- LDA (opcode 5): `rd`=1 in phases 1–3 and 5–7, `ld_ac`=1 only in phase 7, `inc_pc` only in phase 4. Next instruction starts at phase 0 after 8 cycles.
- SKZ (opcode 1):
  - `zero`=1 → `inc_pc`=1 in phases 4 and 6.
  - `zero`=0 → `inc_pc`=1 in phase 4 only.
  - `rd`=0 in phases 5–7 in both cases.
- STO/JMP:
  - STO: `data_e`=1 in phases 6–7, `wr`=1 in phase 7 only.
  - JMP: `ld_pc`=1 in phases 6–7, `inc_pc`=1 in phase 7.
- HLT: `halt`=1 in phase 4, then `phase` stays 4 and all strobes except `halt` stay 0 for 20+ cycles. Pulsing `rst_n` low returns to phase 0.
- Macro defined:
  - `mem_ready`=0 for 3 cycles in phase 1 → `phase`=1 for 4 cycles, then phase 2.
  - `mem_ready` held 0 in phase 7 of STO with `WAIT_TIMEOUT`=15 → `mem_err`=1 and `halt`=1 after 15 held cycles, and `phase` stays 7.
